// File: rtl/key_hit_queue.sv
// Keyboard hit queue: maps PS/2 key presses onto hole positions and buffers
// them in a small FIFO for the game logic to consume in arrival order.
module key_hit_queue #(
    parameter int NUM_POS = 9,
    parameter int DEPTH   = 4,
    parameter int MODE    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         key_valid,
    input  logic [8:0]                   last_change,
    input  logic [511:0]                 key_down,
    input  logic                         enable,
    input  logic                         pop,
    input  logic                         clr_overflow,
    output logic                         hit,
    output logic [3:0]                   hit_pos,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    function automatic logic [3:0] code_to_pos(input logic [8:0] code);
        case (code)
            9'h015:  code_to_pos = 4'd0;
            9'h01D:  code_to_pos = 4'd1;
            9'h024:  code_to_pos = 4'd2;
            9'h01C:  code_to_pos = 4'd3;
            9'h01B:  code_to_pos = 4'd4;
            9'h023:  code_to_pos = 4'd5;
            9'h01A:  code_to_pos = 4'd6;
            9'h022:  code_to_pos = 4'd7;
            9'h021:  code_to_pos = 4'd8;
            9'h02D:  code_to_pos = 4'd9;
            9'h02B:  code_to_pos = 4'd10;
            9'h02A:  code_to_pos = 4'd11;
            9'h02C:  code_to_pos = 4'd12;
            9'h034:  code_to_pos = 4'd13;
            9'h032:  code_to_pos = 4'd14;
            default: code_to_pos = 4'd15;
        endcase
    endfunction

    function automatic logic [8:0] pos_to_code(input int p);
        case (p)
            0:       pos_to_code = 9'h015;
            1:       pos_to_code = 9'h01D;
            2:       pos_to_code = 9'h024;
            3:       pos_to_code = 9'h01C;
            4:       pos_to_code = 9'h01B;
            5:       pos_to_code = 9'h023;
            6:       pos_to_code = 9'h01A;
            7:       pos_to_code = 9'h022;
            8:       pos_to_code = 9'h021;
            9:       pos_to_code = 9'h02D;
            10:      pos_to_code = 9'h02B;
            11:      pos_to_code = 9'h02A;
            12:      pos_to_code = 9'h02C;
            13:      pos_to_code = 9'h034;
            14:      pos_to_code = 9'h032;
            default: pos_to_code = 9'h000;
        endcase
    endfunction

    logic [NUM_POS-1:0] held_mask_q, held_mask_d;
    logic [3:0]         mem_q [DEPTH];
    logic [3:0]         mem_d [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;

    logic [15:0]        held_wide;
    logic [3:0]         press_pos;
    logic               press, accept, want_push, full, do_push, do_pop, ovf_event;

    always_comb begin
        held_mask_d = '0;
        for (int p = 0; p < NUM_POS; p++) begin
            held_mask_d[p] = key_down[pos_to_code(p)];
        end
    end

    always_comb begin
        held_wide = 16'(held_mask_q);
        press_pos = code_to_pos(last_change);
        press     = key_valid && key_down[last_change] &&
                    (press_pos != 4'd15) && (int'(press_pos) < NUM_POS);
        // Acceptance uses last cycle's held state, so the key causing this strobe
        // never blocks itself but its typematic repeats do.
        if (MODE == 0) begin
            accept = (held_mask_q == '0);
        end else begin
            accept = !held_wide[press_pos];
        end
        want_push = press && accept && enable;
        full      = (count_q == CW'(DEPTH));
        do_pop    = pop && (count_q != '0);
        do_push   = want_push && (!full || do_pop);
        ovf_event = want_push && full && !do_pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            mem_d[wr_ptr_q] = press_pos;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (do_push && !do_pop) begin
            count_d = count_q + CW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CW'(1);
        end

        overflow_d = (overflow_q && !clr_overflow) || ovf_event;

        if (!enable) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_mask_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 4'd0;
            end
        end else begin
            held_mask_q <= held_mask_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            mem_q       <= mem_d;
        end
    end

    assign hit      = (count_q != '0);
    assign hit_pos  = hit ? mem_q[rd_ptr_q] : 4'd15;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule
